// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready flow control,
// sync flush (bubble injection) and a saturating stall counter.
//   clk        in   rising-edge clock
//   reset      in   async active-high reset
//   flush      in   sync kill of all held entries; the accept in that cycle is dropped
//   in_valid   in   upstream entry present
//   in_ready   out  stage can accept this cycle
//   in_ctrl    in   upstream control field
//   in_data    in   upstream payload
//   out_valid  out  entry present at output
//   out_ready  in   downstream accepts this cycle
//   out_ctrl   out  registered control field (0 = NOP bubble when empty)
//   out_data   out  registered payload (holds its last value when empty)
//   stall_cnt  out  saturating count of cycles with out_valid & !out_ready
// Build option: define PIPE_STAGE_SKID_EN to add one skid entry, so that
// in_ready comes straight from a flop and out_ready has no combinational path to it.
module pipe_stage_reg #(
    parameter int CTRL_W      = 32,
    parameter int DATA_W      = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic accept, issue, stall;
    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;
    assign stall  = out_valid & ~out_ready;
`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    assign in_ready = ~skid_valid;
    // The main register is free when it is empty or draining this cycle.
    // The skid is only full while in_ready is low, so it never competes with an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || issue) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_ctrl   <= skid_ctrl;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_ctrl  <= in_ctrl;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
        end else if (issue) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
